// File: rtl/alu_step_pkg.sv
// Shared types and constants for the ALU step sequencer: state encoding,
// LED phase patterns and opcode width.
package alu_step_pkg;

  localparam int OP_W = 4;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_EXEC   = 2'd2,
    ST_SHOW   = 2'd3
  } step_state_e;

  localparam logic [3:0] PH_LOAD_A = 4'b0001;
  localparam logic [3:0] PH_LOAD_B = 4'b0010;
  localparam logic [3:0] PH_EXEC   = 4'b0100;
  localparam logic [3:0] PH_SHOW   = 4'b1000;

  function automatic logic [3:0] phase_of(step_state_e s);
    logic [3:0] ph;
    ph = PH_LOAD_A;
    case (s)
      ST_LOAD_A: ph = PH_LOAD_A;
      ST_LOAD_B: ph = PH_LOAD_B;
      ST_EXEC:   ph = PH_EXEC;
      ST_SHOW:   ph = PH_SHOW;
      default:   ph = PH_LOAD_A;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, level debounce, and a single
// cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic evt
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_prev_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // The level is accepted only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync2_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q    <= '0;
      stable_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_prev_q <= 1'b0;
    end else begin
      stable_prev_q <= stable_q;
    end
  end

  assign evt = stable_q & ~stable_prev_q;

endmodule

// File: rtl/alu_step_ctrl.sv
// Sequencer turning debounced STEP/CLEAR buttons into load-A, load-B,
// execute and show strobes for the ALU board registers.
//
// state   | meaning
// LOAD_A  | waiting for STEP to capture operand A
// LOAD_B  | waiting for STEP to capture operand B and latch the opcode
// EXEC    | ALU settling; load_f fires after SETTLE_CYCLES
// SHOW    | result visible, done high; STEP starts the next operation
module alu_step_ctrl
  import alu_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_step,
  input  logic            btn_clear,
  input  logic [OP_W-1:0] sw_op,
  output logic            load_a,
  output logic            load_b,
  output logic            load_f,
  output logic [OP_W-1:0] alu_op,
  output logic [3:0]      phase,
  output logic            done
);

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);

  logic step_evt;
  logic clear_evt;

  step_state_e     state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic            load_a_d, load_b_d, load_f_d;
  logic            load_a_q, load_b_q, load_f_q;
  logic [3:0]      phase_q;
  logic            done_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_step),
    .evt     (step_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clear),
    .evt     (clear_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD_A;
      settle_q <= '0;
      alu_op_q <= '0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      load_f_q <= 1'b0;
      phase_q  <= PH_LOAD_A;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      alu_op_q <= alu_op_d;
      load_a_q <= load_a_d;
      load_b_q <= load_b_d;
      load_f_q <= load_f_d;
      phase_q  <= phase_of(state_d);
      done_q   <= (state_d == ST_SHOW);
    end
  end

  // CLEAR overrides everything, including an in-flight EXEC, so load_f is never issued after it.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    alu_op_d = alu_op_q;
    load_a_d = 1'b0;
    load_b_d = 1'b0;
    load_f_d = 1'b0;
    if (clear_evt) begin
      state_d = ST_LOAD_A;
    end else begin
      case (state_q)
        ST_LOAD_A: begin
          if (step_evt) begin
            load_a_d = 1'b1;
            state_d  = ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (step_evt) begin
            load_b_d = 1'b1;
            alu_op_d = sw_op;
            settle_d = '0;
            state_d  = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (settle_q == SETTLE_MAX) begin
            load_f_d = 1'b1;
            state_d  = ST_SHOW;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (step_evt) begin
            load_a_d = 1'b1;
            state_d  = ST_LOAD_B;
          end
        end
        default: state_d = ST_LOAD_A;
      endcase
    end
  end

  assign load_a = load_a_q;
  assign load_b = load_b_q;
  assign load_f = load_f_q;
  assign alu_op = alu_op_q;
  assign phase  = phase_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_step_ctrl.sv
// Directed bench for alu_step_ctrl: one instance with SETTLE_CYCLES=2 and a
// second with SETTLE_CYCLES=8 for the EXEC abort and step-ignore cases.
module tb_alu_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_step = 1'b0, btn_clear = 1'b0;
  logic [3:0] sw_op = 4'h0;
  logic       load_a, load_b, load_f, done;
  logic [3:0] alu_op, phase;

  logic       btn_step_8 = 1'b0, btn_clear_8 = 1'b0;
  logic [3:0] sw_op_8 = 4'h0;
  logic       load_a_8, load_b_8, load_f_8, done_8;
  logic [3:0] alu_op_8, phase_8;

  always #5 clk = ~clk;

  alu_step_ctrl #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_clear(btn_clear),
    .sw_op(sw_op), .load_a(load_a), .load_b(load_b), .load_f(load_f),
    .alu_op(alu_op), .phase(phase), .done(done)
  );

  alu_step_ctrl #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step_8), .btn_clear(btn_clear_8),
    .sw_op(sw_op_8), .load_a(load_a_8), .load_b(load_b_8), .load_f(load_f_8),
    .alu_op(alu_op_8), .phase(phase_8), .done(done_8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int na = 0, nb = 0, nf = 0, last_a = 0, last_b = 0, last_f = 0, excl_err = 0;
  int n8a = 0, n8b = 0, n8f = 0, last8_b = 0, last8_f = 0, excl8_err = 0;

  always @(negedge clk) begin
    if (load_a) begin na++; last_a = cyc; end
    if (load_b) begin nb++; last_b = cyc; end
    if (load_f) begin nf++; last_f = cyc; end
    if ((int'(load_a) + int'(load_b) + int'(load_f)) > 1) excl_err++;
    if (load_a_8) n8a++;
    if (load_b_8) begin n8b++; last8_b = cyc; end
    if (load_f_8) begin n8f++; last8_f = cyc; end
    if ((int'(load_a_8) + int'(load_b_8) + int'(load_f_8)) > 1) excl8_err++;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // mode: 0 = step, 1 = clear, 2 = step and clear together
  typedef struct {
    int         mode;
    logic [3:0] sw;
    int         ea, eb, ef;
    logic [3:0] eph;
    logic [3:0] eop;
    logic       edone;
  } vec_t;

  vec_t vecs[9];

  task automatic press(input int mode, input logic [3:0] sw);
    @(negedge clk);
    sw_op     = sw;
    btn_step  = (mode != 1);
    btn_clear = (mode != 0);
    repeat (20) @(negedge clk);
    btn_step  = 1'b0;
    btn_clear = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic press8(input logic [3:0] sw);
    @(negedge clk);
    sw_op_8    = sw;
    btn_step_8 = 1'b1;
    repeat (20) @(negedge clk);
    btn_step_8 = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int a0, b0, f0, c0;
    bit found;

    vecs[0] = '{0, 4'h3, 0, 1, 1, 4'b1000, 4'h3, 1'b1};
    vecs[1] = '{0, 4'hC, 1, 0, 0, 4'b0010, 4'h3, 1'b0};
    vecs[2] = '{1, 4'h0, 0, 0, 0, 4'b0001, 4'h3, 1'b0};
    vecs[3] = '{1, 4'h0, 0, 0, 0, 4'b0001, 4'h3, 1'b0};
    vecs[4] = '{0, 4'h5, 1, 0, 0, 4'b0010, 4'h3, 1'b0};
    vecs[5] = '{0, 4'hF, 0, 1, 1, 4'b1000, 4'hF, 1'b1};
    vecs[6] = '{1, 4'h1, 0, 0, 0, 4'b0001, 4'hF, 1'b0};
    vecs[7] = '{0, 4'h2, 1, 0, 0, 4'b0010, 4'hF, 1'b0};
    vecs[8] = '{2, 4'h4, 0, 0, 0, 4'b0001, 4'hF, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_phase", phase, 4'b0001);
    check("reset_alu_op", alu_op, 4'h0);
    check("reset_strobes", {load_a, load_b, load_f}, 3'b000);
    check("reset_done", done, 1'b0);
    check("reset_phase8", phase_8, 4'b0001);

    // First press: exact raw-edge to load_a latency
    @(negedge clk);
    sw_op = 4'hA;
    c0 = cyc;
    a0 = na;
    btn_step = 1'b1;
    repeat (20) @(negedge clk);
    check("lat_load_a_count", na - a0, 1);
    check("lat_load_a_cycles", last_a - c0, 7);
    btn_step = 1'b0;
    repeat (20) @(negedge clk);
    check("lat_phase", phase, 4'b0010);
    check("lat_alu_op", alu_op, 4'h0);

    for (int i = 0; i < 9; i++) begin
      a0 = na; b0 = nb; f0 = nf;
      press(vecs[i].mode, vecs[i].sw);
      check($sformatf("v%0d_load_a", i), na - a0, vecs[i].ea);
      check($sformatf("v%0d_load_b", i), nb - b0, vecs[i].eb);
      check($sformatf("v%0d_load_f", i), nf - f0, vecs[i].ef);
      check($sformatf("v%0d_phase", i), phase, vecs[i].eph);
      check($sformatf("v%0d_alu_op", i), alu_op, vecs[i].eop);
      check($sformatf("v%0d_done", i), done, vecs[i].edone);
      if (vecs[i].ef == 1) check($sformatf("v%0d_b_to_f", i), last_f - last_b, 2);
    end

    // Glitch of 3 cycles: no event
    a0 = na;
    @(negedge clk);
    btn_step = 1'b1;
    repeat (3) @(negedge clk);
    btn_step = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_no_load_a", na - a0, 0);
    check("glitch_phase", phase, 4'b0001);

    // Bounce then hold: exactly one event
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1;
      repeat (2) @(negedge clk);
      btn_step = 1'b0;
      repeat (2) @(negedge clk);
    end
    btn_step = 1'b1;
    repeat (20) @(negedge clk);
    check("bounce_one_load_a", na - a0, 1);
    check("bounce_phase", phase, 4'b0010);
    btn_step = 1'b0;
    repeat (20) @(negedge clk);

    // Async reset while load_b is high, entering EXEC
    sw_op = 4'h6;
    btn_step = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (load_b) found = 1'b1;
    end
    check("rst_saw_load_b", found, 1'b1);
    #1 rst_n = 1'b0;
    btn_step = 1'b0;
    #1;
    check("rst_async_load_b", load_b, 1'b0);
    check("rst_async_load_f", load_f, 1'b0);
    check("rst_async_phase", phase, 4'b0001);
    check("rst_async_alu_op", alu_op, 4'h0);
    check("rst_async_done", done, 1'b0);
    #1 rst_n = 1'b1;
    f0 = nf;
    repeat (20) @(negedge clk);
    check("rst_no_load_f", nf - f0, 0);
    check("rst_phase_after", phase, 4'b0001);

    // SETTLE_CYCLES=8 instance: A, then B with a step that lands in EXEC
    a0 = n8a;
    press8(4'h0);
    check("s8_load_a", n8a - a0, 1);
    a0 = n8a; b0 = n8b; f0 = n8f;
    @(negedge clk);
    sw_op_8 = 4'h9;
    c0 = cyc;
    btn_step_8 = 1'b1;
    repeat (4) @(negedge clk);
    btn_step_8 = 1'b0;
    repeat (4) @(negedge clk);
    btn_step_8 = 1'b1;
    repeat (30) @(negedge clk);
    check("s8_load_b_count", n8b - b0, 1);
    check("s8_load_b_cycles", last8_b - c0, 7);
    check("s8_load_f_count", n8f - f0, 1);
    check("s8_b_to_f", last8_f - last8_b, 8);
    check("s8_step_in_exec_ignored", n8a - a0, 0);
    check("s8_phase_show", phase_8, 4'b1000);
    check("s8_done", done_8, 1'b1);
    check("s8_alu_op", alu_op_8, 4'h9);
    btn_step_8 = 1'b0;
    repeat (20) @(negedge clk);

    a0 = n8a;
    press8(4'h0);
    check("s8_show_load_a", n8a - a0, 1);
    check("s8_phase_load_b", phase_8, 4'b0010);

    // Clear right after load_b aborts EXEC
    b0 = n8b; f0 = n8f;
    @(negedge clk);
    sw_op_8 = 4'h5;
    btn_step_8 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (load_b_8) found = 1'b1;
    end
    check("clr_saw_load_b", found, 1'b1);
    btn_clear_8 = 1'b1;
    repeat (20) @(negedge clk);
    btn_step_8 = 1'b0;
    btn_clear_8 = 1'b0;
    repeat (30) @(negedge clk);
    check("clr_load_b_count", n8b - b0, 1);
    check("clr_no_load_f", n8f - f0, 0);
    check("clr_phase", phase_8, 4'b0001);
    check("clr_alu_op_kept", alu_op_8, 4'h5);
    check("clr_done", done_8, 1'b0);
    sw_op_8 = 4'h7;
    repeat (10) @(negedge clk);
    check("clr_sw_change_ignored", alu_op_8, 4'h5);

    check("excl_main", excl_err, 0);
    check("excl_s8", excl8_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
